store_unit: RTL and testbench

Memory-stage store path of the MIPS pipeline: the write-side counterpart of the write-back data selection. It accepts SB/SH/SW requests from the MEM stage, checks alignment, and places register data onto the correct byte lanes with byte enables. It then drives a req/ack write transaction to data memory and holds the pipeline via a stall until the store retires, faults, or times out.

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/store_lane_align.sv | 37 +++
 rtl/store_unit.sv | 97 +++++++++
 tb/tb_store_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-stage load/store paths:
// access-size encodings, store FSM states and byte-enable constants.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } st_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_align.sv
// Little-endian lane placement and alignment check for SB/SH/SW.
// Purely combinational; the misalign output is also used by the load path.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  st_size_e    size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misalign
);

    always_comb begin
        wdata    = '0;
        be       = BE_NONE;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = BE_BYTE0 << addr;
            end
            SZ_HALF: begin
                wdata    = {2{data[15:0]}};
                be       = addr[1] ? BE_HI_HALF : BE_LO_HALF;
                misalign = addr[0];
            end
            SZ_WORD: begin
                wdata    = data;
                be       = BE_WORD;
                misalign = |addr;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: aligns store data, runs a req/ack write to data
// memory with a bounded wait, and stalls the pipeline until the store retires.
module store_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_stall,
    output logic        st_done,
    output logic        st_misalign,
    output logic        st_fault,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    st_state_e   state;
    logic [7:0]  cnt;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic        al_misalign;
    logic        timeout;
    logic        in_idle;
    logic        in_wait;

    store_lane_align u_align (
        .size     (st_size_e'(st_size)),
        .addr     (st_addr[1:0]),
        .data     (st_data),
        .wdata    (al_wdata),
        .be       (al_be),
        .misalign (al_misalign)
    );

    assign in_idle = (state == IDLE);
    assign in_wait = (state == WAIT_ACK);

    // cnt counts completed unacknowledged WAIT_ACK cycles, so the
    // TIMEOUT-th waiting cycle is the one where cnt == TIMEOUT-1.
    assign timeout = in_wait && (cnt == CNT_LAST);

    always_comb begin
        st_misalign = in_idle && st_valid && al_misalign;
        st_fault    = timeout && !dm_ack;
        st_done     = st_misalign || (in_wait && (dm_ack || timeout));
        st_stall    = st_valid && !st_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dm_req   <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_valid && !al_misalign) begin
                        state    <= WAIT_ACK;
                        cnt      <= '0;
                        dm_req   <= 1'b1;
                        dm_addr  <= {st_addr[31:2], 2'b00};
                        dm_wdata <= al_wdata;
                        dm_be    <= al_be;
                    end
                end
                WAIT_ACK: begin
                    if (dm_ack || timeout) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        dm_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit (TIMEOUT=4): lane placement, misalign,
// ack latency, timeout, back-to-back, flush and mid-transaction reset.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_stall;
    logic        st_done;
    logic        st_misalign;
    logic        st_fault;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    store_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_size     (st_size),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_stall    (st_stall),
        .st_done     (st_done),
        .st_misalign (st_misalign),
        .st_fault    (st_fault),
        .dm_req      (dm_req),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_be       (dm_be),
        .dm_ack      (dm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && dm_req && dm_ack) hs_count <= hs_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let outputs settle.
    task automatic step(input logic v, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic ak);
        @(negedge clk);
        st_valid = v;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
        dm_ack   = ak;
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_req"},  dm_req,  1'b0);
        chk({tag, "_done"}, st_done, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0; dm_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   dm_req,      1'b0);
        chk("rst_be",    dm_be,       4'h0);
        chk("rst_wdata", dm_wdata,    32'h0);
        chk("rst_addr",  dm_addr,     32'h0);
        chk("rst_done",  st_done,     1'b0);
        chk("rst_stall", st_stall,    1'b0);
        chk("rst_mis",   st_misalign, 1'b0);
        chk("rst_fault", st_fault,    1'b0);
        @(negedge clk); rst_n = 1'b1;

        // SW 0x100, ack on first wait cycle
        step(1, 2'b10, 32'h100, 32'hDEADBEEF, 0);
        chk("sw_stall0", st_stall, 1'b1);
        chk("sw_done0",  st_done,  1'b0);
        chk("sw_req0",   dm_req,   1'b0);
        step(1, 2'b10, 32'h100, 32'hDEADBEEF, 1);
        chk("sw_req1",   dm_req,   1'b1);
        chk("sw_addr",   dm_addr,  32'h100);
        chk("sw_be",     dm_be,    4'b1111);
        chk("sw_wdata",  dm_wdata, 32'hDEADBEEF);
        chk("sw_done1",  st_done,  1'b1);
        chk("sw_stall1", st_stall, 1'b0);
        chk("sw_fault",  st_fault, 1'b0);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("sw_after");

        // SB 0x203, ack on 4th wait cycle (coincides with timeout -> success)
        step(1, 2'b00, 32'h203, 32'h000000A5, 0);
        chk("sb_stall0", st_stall, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1, 2'b00, 32'h203, 32'h000000A5, 0);
            chk("sb_req_w",   dm_req,   1'b1);
            chk("sb_stall_w", st_stall, 1'b1);
            chk("sb_done_w",  st_done,  1'b0);
        end
        chk("sb_addr",  dm_addr,  32'h200);
        chk("sb_be",    dm_be,    4'b1000);
        chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
        step(1, 2'b00, 32'h203, 32'h000000A5, 1);
        chk("sb_req4",   dm_req,   1'b1);
        chk("sb_done4",  st_done,  1'b1);
        chk("sb_fault4", st_fault, 1'b0);
        chk("sb_stall4", st_stall, 1'b0);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("sb_after");

        // Misaligned stores retire in the accept cycle with no request
        step(1, 2'b01, 32'h301, 32'h1234, 0);
        chk("shm_done",  st_done,     1'b1);
        chk("shm_mis",   st_misalign, 1'b1);
        chk("shm_stall", st_stall,    1'b0);
        chk("shm_fault", st_fault,    1'b0);
        step(1, 2'b10, 32'h302, 32'h5678, 0);
        chk("swm_req",   dm_req,      1'b0);
        chk("swm_done",  st_done,     1'b1);
        chk("swm_mis",   st_misalign, 1'b1);
        step(1, 2'b11, 32'h300, 32'h0, 0);
        chk("szm_req",   dm_req,      1'b0);
        chk("szm_mis",   st_misalign, 1'b1);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("mis_after");

        // Timeout: no ack for 4 wait cycles
        step(1, 2'b10, 32'h500, 32'h11223344, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 2'b10, 32'h500, 32'h11223344, 0);
            chk("to_req_w",   dm_req,   1'b1);
            chk("to_done_w",  st_done,  1'b0);
            chk("to_fault_w", st_fault, 1'b0);
        end
        step(1, 2'b10, 32'h500, 32'h11223344, 0);
        chk("to_done",  st_done,     1'b1);
        chk("to_fault", st_fault,    1'b1);
        chk("to_mis",   st_misalign, 1'b0);
        chk("to_stall", st_stall,    1'b0);
        step(0, 2'b00, 32'h0, 32'h0, 1);
        chk("to_req_drop", dm_req,  1'b0);
        chk("idle_ack",    st_done, 1'b0);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        chk("idle_ack_req", dm_req, 1'b0);

        // Back-to-back SH 0x402 then SB 0x405
        step(1, 2'b01, 32'h402, 32'h00001234, 0);
        chk("b2b_stall0", st_stall, 1'b1);
        step(1, 2'b01, 32'h402, 32'h00001234, 1);
        chk("b2b_addr0",  dm_addr,  32'h400);
        chk("b2b_be0",    dm_be,    4'b1100);
        chk("b2b_wd0",    dm_wdata, 32'h12341234);
        chk("b2b_done0",  st_done,  1'b1);
        step(1, 2'b00, 32'h405, 32'h00000077, 0);
        chk("b2b_req_gap", dm_req,  1'b0);
        chk("b2b_stall1", st_stall, 1'b1);
        step(1, 2'b00, 32'h405, 32'h00000077, 1);
        chk("b2b_req1",   dm_req,   1'b1);
        chk("b2b_addr1",  dm_addr,  32'h404);
        chk("b2b_be1",    dm_be,    4'b0010);
        chk("b2b_wd1",    dm_wdata, 32'h77777777);
        chk("b2b_done1",  st_done,  1'b1);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("b2b_after");

        // Flush: st_valid drops while waiting; write still completes
        step(1, 2'b10, 32'h600, 32'h0BADF00D, 0);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        chk("fl_req",   dm_req,   1'b1);
        chk("fl_stall", st_stall, 1'b0);
        chk("fl_done0", st_done,  1'b0);
        step(0, 2'b00, 32'h0, 32'h0, 1);
        chk("fl_done1", st_done,  1'b1);
        chk("fl_wd",    dm_wdata, 32'h0BADF00D);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("fl_after");

        // Asynchronous reset mid-transaction
        step(1, 2'b10, 32'h700, 32'hCAFEF00D, 0);
        step(1, 2'b10, 32'h700, 32'hCAFEF00D, 0);
        chk("ar_req_pre", dm_req, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_req_async", dm_req, 1'b0);
        chk("ar_be_async",  dm_be,  4'h0);
        st_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        idle_chk("ar_after");
        step(1, 2'b00, 32'h001, 32'h000000FF, 0);
        chk("ar_stall", st_stall, 1'b1);
        step(1, 2'b00, 32'h001, 32'h000000FF, 1);
        chk("ar_addr", dm_addr,  32'h0);
        chk("ar_be",   dm_be,    4'b0010);
        chk("ar_wd",   dm_wdata, 32'hFFFFFFFF);
        chk("ar_done", st_done,  1'b1);
        step(0, 2'b00, 32'h0, 32'h0, 0);
        idle_chk("ar_end");

        @(negedge clk);
        chk("handshakes", hs_count, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
